// File: rtl/order_msg_ingress.sv
// order_msg_ingress: assembles 8-word host messages, drops malformed ones, buffers whole messages in a FIFO
//   i_clk, i_reset (async, active-high), i_flush (sync clear, error count kept)
//   i_wdata/i_wvalid/i_wlast/o_wready : host word stream
//   o_reg_1..o_reg_8/o_valid/i_ready  : FIFO head message with valid/ready handshake
//   o_count : messages stored, o_err_count : dropped malformed messages (saturating)
module order_msg_ingress #(
  parameter int DATA_WIDTH    = 32,
  parameter int WORDS_PER_MSG = 8,
  parameter int BUFFER_SIZE   = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic                         i_wvalid,
  input  logic                         i_wlast,
  output logic                         o_wready,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_reg_1,
  output logic [DATA_WIDTH-1:0]        o_reg_2,
  output logic [DATA_WIDTH-1:0]        o_reg_3,
  output logic [DATA_WIDTH-1:0]        o_reg_4,
  output logic [DATA_WIDTH-1:0]        o_reg_5,
  output logic [DATA_WIDTH-1:0]        o_reg_6,
  output logic [DATA_WIDTH-1:0]        o_reg_7,
  output logic [DATA_WIDTH-1:0]        o_reg_8,
  output logic                         o_valid,
  output logic [$clog2(BUFFER_SIZE):0] o_count,
  output logic [15:0]                  o_err_count
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int MW = DATA_WIDTH * WORDS_PER_MSG;
  localparam logic [2:0] LAST = 3'(WORDS_PER_MSG - 1);
  typedef enum logic {ASSEMBLE, DROP} state_t;
  state_t r_state, w_state_nx;
  logic [2:0] r_idx, w_idx_nx;
  logic [DATA_WIDTH-1:0] r_asm [7];
  logic [MW-1:0] r_mem [BUFFER_SIZE];
  logic [MW-1:0] r_head, w_msg;
  logic [AW:0] r_wr, r_rd, w_wr_nx, w_rd_nx;
  logic [15:0] r_err;
  logic w_acc, w_full, w_push, w_pop, w_err;
  assign w_acc   = i_wvalid && o_wready;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_valid = r_wr != r_rd;
  assign o_count = r_wr - r_rd;
  assign w_pop   = o_valid && i_ready;
  assign w_wr_nx = r_wr + {{AW{1'b0}}, w_push};
  assign w_rd_nx = r_rd + {{AW{1'b0}}, w_pop};
  // the completing word goes straight into the FIFO entry, it is never held in r_asm
  assign w_msg = {i_wdata, r_asm[6], r_asm[5], r_asm[4], r_asm[3], r_asm[2], r_asm[1], r_asm[0]};
  assign o_reg_1 = r_head[0*DATA_WIDTH +: DATA_WIDTH];
  assign o_reg_2 = r_head[1*DATA_WIDTH +: DATA_WIDTH];
  assign o_reg_3 = r_head[2*DATA_WIDTH +: DATA_WIDTH];
  assign o_reg_4 = r_head[3*DATA_WIDTH +: DATA_WIDTH];
  assign o_reg_5 = r_head[4*DATA_WIDTH +: DATA_WIDTH];
  assign o_reg_6 = r_head[5*DATA_WIDTH +: DATA_WIDTH];
  assign o_reg_7 = r_head[6*DATA_WIDTH +: DATA_WIDTH];
  assign o_reg_8 = r_head[7*DATA_WIDTH +: DATA_WIDTH];
  assign o_err_count = r_err;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= ASSEMBLE;
      r_idx   <= 3'd0;
    end else if (i_flush) begin
      r_state <= ASSEMBLE;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
    end
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    if (w_acc && r_state == DROP)
      w_state_nx = i_wlast ? ASSEMBLE : DROP;
    else if (w_acc) begin
      w_idx_nx   = (i_wlast || r_idx == LAST) ? 3'd0 : r_idx + 3'd1;
      w_state_nx = (r_idx == LAST && !i_wlast) ? DROP : ASSEMBLE;
    end
  end
  // only the completing word can stall; earlier words never need a free slot
  always_comb begin
    o_wready = (r_state == DROP) || (r_idx != LAST) || !w_full;
    w_push   = w_acc && r_state == ASSEMBLE && r_idx == LAST && i_wlast;
    w_err    = w_acc && r_state == ASSEMBLE && ((r_idx == LAST) ? !i_wlast : i_wlast);
  end
  always_ff @(posedge i_clk)
    if (w_acc && r_state == ASSEMBLE && r_idx != LAST) r_asm[r_idx] <= i_wdata;
  always_ff @(posedge i_clk)
    if (w_push && !i_flush) r_mem[r_wr[AW-1:0]] <= w_msg;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else if (i_flush) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr <= w_wr_nx;
      r_rd <= w_rd_nx;
      // preload next head; bypass when the next head is the entry written this cycle
      if (w_rd_nx != w_wr_nx) r_head <= (w_push && w_rd_nx == r_wr) ? w_msg : r_mem[w_rd_nx[AW-1:0]];
    end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_err <= '0;
    else if (!i_flush && w_err && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
endmodule

// File: tb/tb_order_msg_ingress.sv
// tb_order_msg_ingress: directed self-checking bench for order_msg_ingress
module tb_order_msg_ingress;
  logic clk = 1'b0;
  logic i_reset = 1'b1, i_flush = 1'b0, i_wvalid = 1'b0, i_wlast = 1'b0, i_ready = 1'b0;
  logic [31:0] i_wdata = '0;
  logic o_wready, o_valid;
  logic [31:0] o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6, o_reg_7, o_reg_8;
  logic [5:0] o_count;
  logic [15:0] o_err_count;
  logic [31:0] regs [8];
  int checks = 0, failures = 0, stalls = 0;
  order_msg_ingress dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .i_wlast(i_wlast), .o_wready(o_wready),
    .i_ready(i_ready),
    .o_reg_1(o_reg_1), .o_reg_2(o_reg_2), .o_reg_3(o_reg_3), .o_reg_4(o_reg_4),
    .o_reg_5(o_reg_5), .o_reg_6(o_reg_6), .o_reg_7(o_reg_7), .o_reg_8(o_reg_8),
    .o_valid(o_valid), .o_count(o_count), .o_err_count(o_err_count)
  );
  assign regs[0] = o_reg_1;
  assign regs[1] = o_reg_2;
  assign regs[2] = o_reg_3;
  assign regs[3] = o_reg_4;
  assign regs[4] = o_reg_5;
  assign regs[5] = o_reg_6;
  assign regs[6] = o_reg_7;
  assign regs[7] = o_reg_8;
  initial forever #5 clk = ~clk;
  task automatic apply_reset();
    i_reset = 1'b1;
    i_flush = 1'b0;
    i_wvalid = 1'b0;
    i_wlast = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
  endtask
  // word k = first + k*step; i_wlast on the final word if last_at_end; optional i_ready pulse on the final word
  task automatic send_words(input logic [31:0] first, input logic [31:0] step, input int n,
                            input bit last_at_end, input bit rdy_last);
    int t;
    bit a;
    for (int k = 0; k < n; k++) begin
      i_wdata = first + 32'(k) * step;
      i_wlast = last_at_end && (k == n - 1);
      i_wvalid = 1'b1;
      if (rdy_last && k == n - 1) i_ready = 1'b1;
      t = 0;
      forever begin
        a = o_wready;
        @(posedge clk);
        #1;
        if (a) break;
        stalls++;
        t++;
        if (t > 100) begin
          checks++;
          failures++;
          $display("FAIL word_accept_timeout word=%0d", k);
          break;
        end
      end
    end
    i_wvalid = 1'b0;
    i_wlast = 1'b0;
    if (rdy_last) i_ready = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", o_valid); end
    checks++; if (o_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_err_count !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", o_err_count); end
    checks++; if (o_wready !== 1'b1) begin failures++; $display("FAIL reset_wready got=%0d exp=1", o_wready); end
    checks++; if (o_reg_1 !== 32'd0 || o_reg_8 !== 32'd0) begin failures++; $display("FAIL reset_regs got=%h/%h exp=0", o_reg_1, o_reg_8); end
  endtask
  task automatic test_basic();
    logic [31:0] e;
    apply_reset();
    i_ready = 1'b1;
    send_words(32'h11, 32'h11, 8, 1, 0);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0d exp=1", o_valid); end
    for (int k = 0; k < 8; k++) begin
      e = 32'h11 * 32'(k + 1);
      checks++; if (regs[k] !== e) begin failures++; $display("FAIL basic_reg%0d got=%h exp=%h", k + 1, regs[k], e); end
    end
    @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%0d exp=0", o_valid); end
    checks++; if (o_count !== 6'd0) begin failures++; $display("FAIL basic_count got=%0d exp=0", o_count); end
    checks++; if (o_reg_1 !== 32'h11) begin failures++; $display("FAIL basic_hold got=%h exp=11", o_reg_1); end
    i_ready = 1'b0;
  endtask
  task automatic test_early_last();
    apply_reset();
    send_words(32'h31, 32'h1, 3, 1, 0);
    send_words(32'hA1, 32'h1, 8, 1, 0);
    checks++; if (o_err_count !== 16'd1) begin failures++; $display("FAIL early_err got=%0d exp=1", o_err_count); end
    checks++; if (o_count !== 6'd1) begin failures++; $display("FAIL early_count got=%0d exp=1", o_count); end
    checks++; if (o_reg_1 !== 32'hA1 || o_reg_8 !== 32'hA8) begin failures++; $display("FAIL early_regs got=%h/%h exp=a1/a8", o_reg_1, o_reg_8); end
  endtask
  task automatic test_missing_last();
    apply_reset();
    stalls = 0;
    send_words(32'h200, 32'h1, 10, 1, 0);
    checks++; if (stalls != 0) begin failures++; $display("FAIL missing_stalls got=%0d exp=0", stalls); end
    checks++; if (o_err_count !== 16'd1) begin failures++; $display("FAIL missing_err got=%0d exp=1", o_err_count); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL missing_valid got=%0d exp=0", o_valid); end
    send_words(32'hB1, 32'h1, 8, 1, 0);
    checks++; if (o_count !== 6'd1) begin failures++; $display("FAIL missing_count got=%0d exp=1", o_count); end
    checks++; if (o_reg_1 !== 32'hB1 || o_reg_8 !== 32'hB8) begin failures++; $display("FAIL missing_regs got=%h/%h exp=b1/b8", o_reg_1, o_reg_8); end
    checks++; if (o_err_count !== 16'd1) begin failures++; $display("FAIL missing_err_after got=%0d exp=1", o_err_count); end
  endtask
  task automatic test_full();
    apply_reset();
    for (int m = 0; m < 32; m++) send_words(32'(m), 32'h100, 8, 1, 0);
    checks++; if (o_count !== 6'd32) begin failures++; $display("FAIL full_count got=%0d exp=32", o_count); end
    checks++; if (o_reg_1 !== 32'd0) begin failures++; $display("FAIL full_head got=%0d exp=0", o_reg_1); end
    send_words(32'd32, 32'h100, 7, 0, 0);
    i_wdata = 32'd32 + 32'h700;
    i_wlast = 1'b1;
    i_wvalid = 1'b1;
    checks++; if (o_wready !== 1'b0) begin failures++; $display("FAIL full_wready got=%0d exp=0", o_wready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_wready !== 1'b0 || o_count !== 6'd32) begin failures++; $display("FAIL full_stall got=%0d/%0d exp=0/32", o_wready, o_count); end
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    checks++; if (o_count !== 6'd31 || o_wready !== 1'b1) begin failures++; $display("FAIL full_pop got=%0d/%0d exp=31/1", o_count, o_wready); end
    @(posedge clk);
    #1;
    i_wvalid = 1'b0;
    i_wlast = 1'b0;
    checks++; if (o_count !== 6'd32) begin failures++; $display("FAIL full_refill got=%0d exp=32", o_count); end
    i_ready = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      checks++; if (o_valid !== 1'b1 || o_reg_1 !== 32'(k)) begin failures++; $display("FAIL drain_%0d got=%0d/%0d exp=1/%0d", k, o_valid, o_reg_1, k); end
      @(posedge clk);
      #1;
    end
    i_ready = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_count !== 6'd0) begin failures++; $display("FAIL drain_empty got=%0d/%0d exp=0/0", o_valid, o_count); end
    checks++; if (o_reg_8 !== 32'd32 + 32'h700) begin failures++; $display("FAIL drain_last_word got=%h exp=%h", o_reg_8, 32'd32 + 32'h700); end
  endtask
  task automatic test_back_to_back();
    apply_reset();
    for (int m = 0; m < 5; m++) send_words(32'h50 + 32'(m), 32'h100, 8, 1, 0);
    for (int j = 0; j < 3; j++) begin
      send_words(32'h60 + 32'(j), 32'h100, 8, 1, 1);
      checks++; if (o_count !== 6'd5) begin failures++; $display("FAIL pushpop_count_%0d got=%0d exp=5", j, o_count); end
      checks++; if (o_reg_1 !== 32'h51 + 32'(j)) begin failures++; $display("FAIL pushpop_head_%0d got=%h exp=%h", j, o_reg_1, 32'h51 + 32'(j)); end
    end
  endtask
  task automatic test_reset_flush();
    apply_reset();
    send_words(32'hD0, 32'h1, 4, 0, 0);
    i_reset = 1'b1;
    #2 i_reset = 1'b0;
    send_words(32'hC1, 32'h1, 8, 1, 0);
    checks++; if (o_count !== 6'd1) begin failures++; $display("FAIL rst_mid_count got=%0d exp=1", o_count); end
    checks++; if (o_reg_1 !== 32'hC1 || o_reg_8 !== 32'hC8) begin failures++; $display("FAIL rst_mid_regs got=%h/%h exp=c1/c8", o_reg_1, o_reg_8); end
    checks++; if (o_err_count !== 16'd0) begin failures++; $display("FAIL rst_mid_err got=%0d exp=0", o_err_count); end
    send_words(32'hC9, 32'h1, 8, 1, 0);
    send_words(32'hD9, 32'h1, 8, 1, 0);
    send_words(32'hF1, 32'h1, 2, 1, 0);
    checks++; if (o_count !== 6'd3 || o_err_count !== 16'd1) begin failures++; $display("FAIL pre_flush got=%0d/%0d exp=3/1", o_count, o_err_count); end
    send_words(32'hF5, 32'h1, 3, 0, 0);
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_count !== 6'd0) begin failures++; $display("FAIL flush_empty got=%0d/%0d exp=0/0", o_valid, o_count); end
    checks++; if (o_err_count !== 16'd1) begin failures++; $display("FAIL flush_err got=%0d exp=1", o_err_count); end
    checks++; if (o_reg_1 !== 32'd0) begin failures++; $display("FAIL flush_regs got=%h exp=0", o_reg_1); end
    send_words(32'hE1, 32'h1, 8, 1, 0);
    checks++; if (o_count !== 6'd1 || o_reg_1 !== 32'hE1 || o_err_count !== 16'd1) begin failures++; $display("FAIL post_flush got=%0d/%h/%0d exp=1/e1/1", o_count, o_reg_1, o_err_count); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_early_last();
    test_missing_last();
    test_full();
    test_back_to_back();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/order_msg_ingress.md
Name: order_msg_ingress

Overview:
- Upstream neighbour of the trading pipeline top level. Accepts order messages from the host as a stream of 32-bit words, 8 words per message.
- Assembles each message and buffers whole messages in a message FIFO.
- Presents each buffered message as eight parallel registers (o_reg_1..o_reg_8) with a valid/ready handshake, directly feeding the parser's i_reg_1..i_reg_8 inputs.
- Malformed messages are dropped and counted.

Parameters:
- DATA_WIDTH, 32: width of each message word and each output register.
- WORDS_PER_MSG, 8: words per message. Fixed at 8; the port list depends on it.
- BUFFER_SIZE, 32: FIFO depth in whole messages. Must be a power of 2, at least 2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous clear of the FIFO and the assembler.
- i_wdata  in  DATA_WIDTH  host word.
- i_wvalid  in  1  host word valid.
- i_wlast  in  1  marks the final word of a message.
- o_wready  out  1  word accepted when i_wvalid && o_wready.
- i_ready  in  1  downstream can take a message (top level drives it as !book_is_busy).
- o_reg_1..o_reg_8  out  DATA_WIDTH each  message words 0..7 of the FIFO head.
- o_valid  out  1  head message valid.
- o_count  out  $clog2(BUFFER_SIZE)+1  messages currently stored.
- o_err_count  out  16  count of dropped malformed messages; saturates at 0xFFFF.

Behaviour:
- Reset (async, i_reset=1):
  - Word index = 0; state = ASSEMBLE.
  - FIFO empty; o_valid=0; o_count=0; o_err_count=0.
  - o_reg_1..8 = 0; o_wready = 1 after release.
  - A reset mid-message discards the partial message; no error is counted.
- i_flush (synchronous) does the same as reset except o_err_count, which is kept. i_flush has priority over push and pop in the same cycle.
- Assembler states:
  - ASSEMBLE: an accepted word is stored at the current index, and the index increments.
    - Index 0..6 with i_wlast=1 → early last. Discard the partial message, o_err_count+1, index=0, stay in ASSEMBLE.
    - Index 7 with i_wlast=1 → the complete message is pushed into the FIFO in the same cycle; index=0.
    - Index 7 with i_wlast=0 → missing last. Discard the message, o_err_count+1, go to DROP.
  - DROP: accept and discard words until a word with i_wlast=1 arrives, then index=0 and return to ASSEMBLE. No additional error count.
- o_wready:
  - In DROP: always 1.
  - In ASSEMBLE: 1 unless index==7 and the FIFO is full. Only the completing word stalls; words 0..6 are always accepted.
- Output side:
  - Head words are driven from registers.
  - Pop when o_valid && i_ready. The next head appears on the following cycle.
  - o_reg_* hold their last value while o_valid=0.
- Latency: word 7 accepted in cycle N → o_valid=1 and o_reg_* valid in cycle N+1 (FIFO was empty).
- Simultaneous push and pop:
  - Allowed when the FIFO is not full; o_count is unchanged.
  - When the FIFO is full, no push can occur (o_wready=0 on word 7). A pop in that cycle frees a slot, so word 7 is accepted the following cycle. There is no same-cycle bypass.
- Pointers are log2(BUFFER_SIZE)+1 bits and wrap naturally. Full = MSBs differ and the lower bits are equal.
- o_valid stays 1 while o_count>0. Order is strictly FIFO.
- Behaviour with i_wvalid=0 is idle: no state change. i_wdata and i_wlast are ignored when i_wvalid=0.

Test Plan:
- Basic message:
  - Stimulus: after reset, send words 0x11,0x22,…,0x88 back to back, with i_wlast on 0x88; i_ready=1.
  - Response: o_valid=1 for exactly 1 cycle, on the cycle after 0x88 is accepted. o_reg_1=0x11 … o_reg_8=0x88. o_count returns to 0.
- Early last:
  - Stimulus: 3 words with i_wlast on the 3rd, followed by a good message A1..A8.
  - Response: o_err_count=1; only message A is output, with o_reg_1=A1.
- Missing last:
  - Stimulus: 10 words with i_wlast on the 10th, followed by a good message.
  - Response: o_err_count=1; all 10 words are accepted with o_wready=1; only the good message is output.
- Full and backpressure:
  - Stimulus: i_ready=0; send 33 messages, each word 0 = message number.
  - Response: o_count=32; o_wready=0 on word 7 of message 33. Raising i_ready for 1 cycle pops message 0 and message 33 then completes. Draining yields o_reg_1 = 1..32 in order.
- Simultaneous push and pop:
  - Stimulus: continuous messages with i_ready=1 and 5 messages stored.
  - Response: o_count stays at 5 across the cycles that both push and pop.
- Reset and flush mid-message:
  - Stimulus: assert i_reset after 4 words, then send a full message. Separately, assert i_flush with 3 messages stored.
  - Response: after the reset, the message is output correctly and o_err_count=0. After the flush, o_valid=0 and o_count=0 next cycle, and o_err_count is unchanged.
